// File: rtl/mem_arbiter.sv
// Byte-wide RAM port arbiter between instruction fetch and the MEM stage.
// Serialises 1/2/4-byte accesses and assembles little-endian read data.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              jumpout,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       if_data,
  output logic              if_done,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_size,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic [31:0]       mem_rdata,
  output logic              mem_done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wr,
  output logic [7:0]        ram_dout,
  input  logic [7:0]        ram_din,
  output logic              stallreq_if,
  output logic              stallreq_mem
);

  typedef enum logic [1:0] {
    IDLE,
    IF_RD,
    MEM_RD,
    MEM_WR
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [2:0]          nbytes_q, nbytes_d;
  logic [23:0]         wdata_q, wdata_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          dout_q, dout_d;
  logic                wr_q, wr_d;
  logic                ifdone_q, ifdone_d;
  logic                memdone_q, memdone_d;
  logic [1:0]          bidx;

  function automatic logic [2:0] size_bytes(input logic [1:0] s);
    case (s)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      nbytes_q  <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      addr_q    <= '0;
      dout_q    <= '0;
      wr_q      <= 1'b0;
      ifdone_q  <= 1'b0;
      memdone_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      nbytes_q  <= nbytes_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      addr_q    <= addr_d;
      dout_q    <= dout_d;
      wr_q      <= wr_d;
      ifdone_q  <= ifdone_d;
      memdone_q <= memdone_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    nbytes_d  = nbytes_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    addr_d    = addr_q;
    dout_d    = dout_q;
    wr_d      = 1'b0;
    ifdone_d  = 1'b0;
    memdone_d = 1'b0;
    // Byte captured at an edge belongs to the address presented two edges earlier.
    bidx      = cnt_q[1:0] - 2'd1;

    unique case (state_q)
      IDLE: begin
        if (mem_req) begin
          nbytes_d = size_bytes(mem_size);
          addr_d   = mem_addr;
          cnt_d    = '0;
          rdata_d  = '0;
          // Store data is kept as a shift register of the bytes still to be sent.
          wdata_d  = mem_wdata[31:8];
          if (mem_we) begin
            dout_d  = mem_wdata[7:0];
            wr_d    = 1'b1;
            state_d = MEM_WR;
          end else begin
            state_d = MEM_RD;
          end
        end else if (if_req && !jumpout) begin
          nbytes_d = 3'd4;
          addr_d   = if_addr;
          cnt_d    = '0;
          rdata_d  = '0;
          state_d  = IF_RD;
        end
      end

      IF_RD, MEM_RD: begin
        if (state_q == IF_RD && jumpout) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          if (cnt_q != '0) begin
            rdata_d[{bidx, 3'b000} +: 8] = ram_din;
          end
          if (cnt_q == nbytes_q) begin
            state_d = IDLE;
            cnt_d   = '0;
            if (state_q == IF_RD) begin
              ifdone_d = 1'b1;
            end else begin
              memdone_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 3'd1;
            if (cnt_q + 3'd1 < nbytes_q) begin
              addr_d = addr_q + ADDR_W'(1);
            end
          end
        end
      end

      MEM_WR: begin
        if (cnt_q + 3'd1 < nbytes_q) begin
          addr_d  = addr_q + ADDR_W'(1);
          dout_d  = wdata_q[7:0];
          wdata_d = {8'h00, wdata_q[23:8]};
          wr_d    = 1'b1;
          cnt_d   = cnt_q + 3'd1;
        end else begin
          memdone_d = 1'b1;
          state_d   = IDLE;
          cnt_d     = '0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign if_data      = rdata_q;
  assign mem_rdata    = rdata_q;
  assign if_done      = ifdone_q;
  assign mem_done     = memdone_q;
  assign ram_addr     = addr_q;
  assign ram_wr       = wr_q;
  assign ram_dout     = dout_q;
  assign stallreq_if  = if_req & ~ifdone_q;
  assign stallreq_mem = mem_req & ~memdone_q;

endmodule
